// File: rtl/fsm_vedacao.sv
// Cork press stage: presses a cork into each full bottle, waits for seat confirmation, then releases it.
// Latency: motor rises one edge after start, stays on TEMPO_PRENSA cycles; release pulses one edge after SENSOR_ROLHA.
// Backpressure: holds in CONFIRMA/VEDADA until sensor/bottle removal; VEDACAO_TIMEOUT_EN adds a confirmation timeout to ERRO.
module fsm_vedacao #(
    parameter int TEMPO_PRENSA      = 50,
    parameter int CAPACIDADE_ROLHAS = 100,
    parameter int ROLHAS_W          = 7,
    parameter int CONT_W            = 16,
    parameter int TIMEOUT           = 200
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic                GARRAFA_CHEIA,
    input  logic                GARRAFA_PRESENTE,
    input  logic                SENSOR_ROLHA,
    input  logic                REPOSICAO,
    output logic                MOTOR_ROLHA,
    output logic                GARRAFA_VEDADA,
    output logic                LIBERA_ESTEIRA,
    output logic                ALARME_ROLHAS,
    output logic                ERRO,
    output logic [ROLHAS_W-1:0] ROLHAS_RESTANTES,
    output logic [CONT_W-1:0]   GARRAFAS_VEDADAS
);

    localparam int TIMER_W = $clog2(TEMPO_PRENSA + 1);

    typedef enum logic [2:0] {
        ST_AGUARDA   = 3'd0,
        ST_PRENSANDO = 3'd1,
        ST_CONFIRMA  = 3'd2,
        ST_VEDADA    = 3'd3,
        ST_SEM_ROLHA = 3'd4,
        ST_ERRO      = 3'd5
    } estado_t;

    estado_t             estado;
    logic [TIMER_W-1:0]  timer;

    // Parameter sanity: the magazine must fit its counter and the timings must be non-zero.
    if (TEMPO_PRENSA < 1 || TIMEOUT < 1 || CAPACIDADE_ROLHAS > (2**ROLHAS_W) - 1) begin : g_param_check
        $error("fsm_vedacao: invalid parameter set");
    end

    assign ALARME_ROLHAS = (ROLHAS_RESTANTES == '0);

`ifdef VEDACAO_TIMEOUT_EN
    localparam int CONF_W = $clog2(TIMEOUT + 1);
    logic [CONF_W-1:0] conf_cnt;
`else
    assign ERRO = 1'b0;
`endif

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            estado           <= ST_AGUARDA;
            timer            <= '0;
            MOTOR_ROLHA      <= 1'b0;
            GARRAFA_VEDADA   <= 1'b0;
            LIBERA_ESTEIRA   <= 1'b0;
            ROLHAS_RESTANTES <= ROLHAS_W'(CAPACIDADE_ROLHAS);
            GARRAFAS_VEDADAS <= '0;
`ifdef VEDACAO_TIMEOUT_EN
            conf_cnt         <= '0;
            ERRO             <= 1'b0;
`endif
        end else begin
            LIBERA_ESTEIRA <= 1'b0;
            case (estado)
                ST_AGUARDA: begin
                    if (GARRAFA_CHEIA && GARRAFA_PRESENTE) begin
                        if (ROLHAS_RESTANTES == '0) begin
                            estado <= ST_SEM_ROLHA;
                        end else begin
                            estado      <= ST_PRENSANDO;
                            timer       <= '0;
                            MOTOR_ROLHA <= 1'b1;
                        end
                    end
                end
                ST_PRENSANDO: begin
                    // Bottle removal aborts before the cork is considered used.
                    if (!GARRAFA_PRESENTE) begin
                        estado      <= ST_AGUARDA;
                        timer       <= '0;
                        MOTOR_ROLHA <= 1'b0;
                    end else if (timer == TIMER_W'(TEMPO_PRENSA - 1)) begin
                        estado           <= ST_CONFIRMA;
                        timer            <= '0;
                        MOTOR_ROLHA      <= 1'b0;
                        ROLHAS_RESTANTES <= ROLHAS_RESTANTES - 1'b1;
`ifdef VEDACAO_TIMEOUT_EN
                        conf_cnt         <= '0;
`endif
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_CONFIRMA: begin
                    if (SENSOR_ROLHA) begin
                        estado         <= ST_VEDADA;
                        GARRAFA_VEDADA <= 1'b1;
                        LIBERA_ESTEIRA <= 1'b1;
                        if (GARRAFAS_VEDADAS != {CONT_W{1'b1}}) begin
                            GARRAFAS_VEDADAS <= GARRAFAS_VEDADAS + 1'b1;
                        end
                    end else if (!GARRAFA_PRESENTE) begin
                        estado <= ST_AGUARDA;
`ifdef VEDACAO_TIMEOUT_EN
                    end else if (conf_cnt == CONF_W'(TIMEOUT - 1)) begin
                        estado <= ST_ERRO;
                        ERRO   <= 1'b1;
                    end else begin
                        conf_cnt <= conf_cnt + 1'b1;
`endif
                    end
                end
                ST_VEDADA: begin
                    if (!GARRAFA_PRESENTE) begin
                        estado         <= ST_AGUARDA;
                        GARRAFA_VEDADA <= 1'b0;
                    end
                end
                ST_SEM_ROLHA: begin
                    if (REPOSICAO) begin
                        estado <= ST_AGUARDA;
                    end
                end
`ifdef VEDACAO_TIMEOUT_EN
                ST_ERRO: begin
                    if (!GARRAFA_PRESENTE) begin
                        estado <= ST_AGUARDA;
                        ERRO   <= 1'b0;
                    end
                end
`endif
                default: begin
                    estado         <= ST_AGUARDA;
                    timer          <= '0;
                    MOTOR_ROLHA    <= 1'b0;
                    GARRAFA_VEDADA <= 1'b0;
`ifdef VEDACAO_TIMEOUT_EN
                    ERRO           <= 1'b0;
`endif
                end
            endcase
            // Placed after the case so a reload overrides a same-edge decrement.
            if (REPOSICAO) begin
                ROLHAS_RESTANTES <= ROLHAS_W'(CAPACIDADE_ROLHAS);
            end
        end
    end

endmodule

// File: tb/tb_fsm_vedacao.sv
// Bench for fsm_vedacao: each driven cycle queues its expected outputs; a monitor pops them 2 time units after the edge.
module tb_fsm_vedacao;

    localparam int TEMPO_PRENSA      = 4;
    localparam int CAPACIDADE_ROLHAS = 3;
    localparam int ROLHAS_W          = 2;
    localparam int CONT_W            = 2;
    localparam int TIMEOUT           = 10;
`ifdef VEDACAO_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic CLOCK = 1'b0;
    logic RESET = 1'b1;
    logic GARRAFA_CHEIA = 1'b0, GARRAFA_PRESENTE = 1'b0, SENSOR_ROLHA = 1'b0, REPOSICAO = 1'b0;
    logic MOTOR_ROLHA, GARRAFA_VEDADA, LIBERA_ESTEIRA, ALARME_ROLHAS, ERRO;
    logic [ROLHAS_W-1:0] ROLHAS_RESTANTES;
    logic [CONT_W-1:0]   GARRAFAS_VEDADAS;

    fsm_vedacao #(
        .TEMPO_PRENSA(TEMPO_PRENSA), .CAPACIDADE_ROLHAS(CAPACIDADE_ROLHAS),
        .ROLHAS_W(ROLHAS_W), .CONT_W(CONT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .GARRAFA_CHEIA(GARRAFA_CHEIA), .GARRAFA_PRESENTE(GARRAFA_PRESENTE),
        .SENSOR_ROLHA(SENSOR_ROLHA), .REPOSICAO(REPOSICAO),
        .MOTOR_ROLHA(MOTOR_ROLHA), .GARRAFA_VEDADA(GARRAFA_VEDADA),
        .LIBERA_ESTEIRA(LIBERA_ESTEIRA), .ALARME_ROLHAS(ALARME_ROLHAS), .ERRO(ERRO),
        .ROLHAS_RESTANTES(ROLHAS_RESTANTES), .GARRAFAS_VEDADAS(GARRAFAS_VEDADAS)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct packed {
        logic       motor;
        logic       vedada;
        logic       libera;
        logic       alarme;
        logic       erro;
        logic [1:0] rolhas;
        logic [1:0] garrafas;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, expv);
        end
    endtask

    task automatic drv(input logic c, p, s, r,
                       input logic m, v, l, a, e, input int rol, input int gar);
        exp_t x;
        @(negedge CLOCK);
        GARRAFA_CHEIA = c; GARRAFA_PRESENTE = p; SENSOR_ROLHA = s; REPOSICAO = r;
        x.motor = m; x.vedada = v; x.libera = l; x.alarme = a; x.erro = e;
        x.rolhas = 2'(rol); x.garrafas = 2'(gar);
        sb.push_back(x);
    endtask

    always @(posedge CLOCK) begin : monitor
        exp_t x;
        #2;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            chk("motor",    32'(MOTOR_ROLHA),      32'(x.motor));
            chk("vedada",   32'(GARRAFA_VEDADA),   32'(x.vedada));
            chk("libera",   32'(LIBERA_ESTEIRA),   32'(x.libera));
            chk("alarme",   32'(ALARME_ROLHAS),    32'(x.alarme));
            chk("erro",     32'(ERRO),             32'(x.erro));
            chk("rolhas",   32'(ROLHAS_RESTANTES), 32'(x.rolhas));
            chk("garrafas", 32'(GARRAFAS_VEDADAS), 32'(x.garrafas));
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        // Reset state
        #12;
        chk("rst_motor",  32'(MOTOR_ROLHA), 0);
        chk("rst_vedada", 32'(GARRAFA_VEDADA), 0);
        chk("rst_libera", 32'(LIBERA_ESTEIRA), 0);
        chk("rst_alarme", 32'(ALARME_ROLHAS), 0);
        chk("rst_erro",   32'(ERRO), 0);
        chk("rst_rolhas", 32'(ROLHAS_RESTANTES), CAPACIDADE_ROLHAS);
        chk("rst_garr",   32'(GARRAFAS_VEDADAS), 0);
        @(negedge CLOCK);
        RESET = 1'b0;

        // Nominal: four motor cycles, cork consumed, sealed, release pulse
        for (int i = 0; i < 4; i++) drv(1,1,0,0, 1,0,0,0,0, 3,0);
        drv(1,1,0,0, 0,0,0,0,0, 2,0);
        drv(1,1,1,0, 0,1,1,0,0, 2,1);
        drv(1,1,0,0, 0,1,0,0,0, 2,1);
        drv(1,1,0,0, 0,1,0,0,0, 2,1);
        drv(1,0,0,0, 0,0,0,0,0, 2,1);
        drv(0,0,0,0, 0,0,0,0,0, 2,1);

        // Abort in the second press cycle: no cork consumed
        drv(1,1,0,0, 1,0,0,0,0, 2,1);
        drv(1,1,0,0, 1,0,0,0,0, 2,1);
        drv(1,0,0,0, 0,0,0,0,0, 2,1);
        drv(0,0,0,0, 0,0,0,0,0, 2,1);

        // Full press after abort; sensor beats presence drop
        for (int i = 0; i < 4; i++) drv(1,1,0,0, 1,0,0,0,0, 2,1);
        drv(1,1,0,0, 0,0,0,0,0, 1,1);
        drv(1,0,1,0, 0,1,1,0,0, 1,2);
        drv(0,0,0,0, 0,0,0,0,0, 1,2);

        // Last cork, then empty magazine
        for (int i = 0; i < 4; i++) drv(1,1,0,0, 1,0,0,0,0, 1,2);
        drv(1,1,0,0, 0,0,0,1,0, 0,2);
        drv(1,1,1,0, 0,1,1,1,0, 0,3);
        drv(1,0,0,0, 0,0,0,1,0, 0,3);
        drv(1,1,0,0, 0,0,0,1,0, 0,3);
        drv(1,1,0,0, 0,0,0,1,0, 0,3);
        drv(1,1,0,1, 0,0,0,0,0, 3,3);
        drv(1,1,0,0, 1,0,0,0,0, 3,3);

        // Reload on the same edge as the decrement
        for (int i = 0; i < 3; i++) drv(1,1,0,0, 1,0,0,0,0, 3,3);
        drv(1,1,0,1, 0,0,0,0,0, 3,3);

        // No confirmation: timeout to ERRO only when the feature is built in
        for (int k = 1; k <= 12; k++) drv(1,1,0,0, 0,0,0,0, (TO_EN && k >= TIMEOUT), 3,3);
        drv(1,0,0,0, 0,0,0,0,0, 3,3);

        // Sealed-bottle counter saturates
        for (int i = 0; i < 4; i++) drv(1,1,0,0, 1,0,0,0,0, 3,3);
        drv(1,1,0,0, 0,0,0,0,0, 2,3);
        drv(1,1,1,0, 0,1,1,0,0, 2,3);
        drv(1,0,0,0, 0,0,0,0,0, 2,3);

        // Asynchronous reset mid-press
        drv(1,1,0,0, 1,0,0,0,0, 2,3);
        drv(1,1,0,0, 1,0,0,0,0, 2,3);
        @(negedge CLOCK);
        #1 RESET = 1'b1;
        #1;
        chk("arst_motor",  32'(MOTOR_ROLHA), 0);
        chk("arst_rolhas", 32'(ROLHAS_RESTANTES), CAPACIDADE_ROLHAS);
        chk("arst_garr",   32'(GARRAFAS_VEDADAS), 0);
        @(posedge CLOCK);
        #2;
        chk("arst_hold_motor", 32'(MOTOR_ROLHA), 0);
        @(negedge CLOCK);
        RESET = 1'b0;
        drv(0,0,0,0, 0,0,0,0,0, 3,0);
        drv(1,1,0,0, 1,0,0,0,0, 3,0);

        @(negedge CLOCK);
        @(negedge CLOCK);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
